// File: rtl/kypd_pkg.sv
// Purpose: shared types, keymap and helpers for the 4x4 matrix keypad scanner.
//   scan_kind_t   : classification of one full scan frame
//   scan_result_t : frame classification plus the decoded key code
//   KEYMAP        : hex value of each key, indexed [row][col]
//   col_state_t   : active column of the scan
package kypd_pkg;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_t;

  typedef struct packed {
    scan_kind_t  kind;
    logic [3:0]  code;
  } scan_result_t;

  localparam scan_result_t RESULT_NONE = '{kind: SCAN_NONE, code: 4'h0};

  // Row-major nibbles, column 0 in the low nibble of each row:
  //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  localparam logic [3:0][3:0][3:0] KEYMAP = {16'hDEF0, 16'hC987, 16'hB654, 16'hA321};

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_t;

  // Number of active-low (pressed) bits in one row sample.
  function automatic logic [2:0] count_lows(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~rows[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/kypd_frame_debounce.sv
// Purpose: frame-level debounce. A frame result is accepted once it has been
// seen on DEBOUNCE_SCANS consecutive frames and differs from the accepted one.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_frame_stb    : one-cycle strobe, i_result is valid
//   i_result       : classification of the frame just completed
//   o_press        : one-cycle pulse on acceptance of a SINGLE result
//   o_key_code     : code of the last accepted SINGLE result
//   o_key_held     : accepted result is a SINGLE
module kypd_frame_debounce
  import kypd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_frame_stb,
  input  scan_result_t i_result,
  output logic         o_press,
  output logic [3:0]   o_key_code,
  output logic         o_key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  scan_result_t     r_prev;
  scan_result_t     r_accepted;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic [3:0]       r_key_code;
  logic             r_key_held;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  // Stability count: saturating run length of identical frame results.
  always_comb begin
    w_cnt_nxt = CNT_W'(1);
    if (i_result == r_prev) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
    w_accept = (w_cnt_nxt == CNT_MAX) && (i_result != r_accepted);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= RESULT_NONE;
      r_accepted <= RESULT_NONE;
      r_cnt      <= '0;
      r_press    <= 1'b0;
      r_key_code <= 4'h0;
      r_key_held <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (i_frame_stb) begin
        r_cnt  <= w_cnt_nxt;
        r_prev <= i_result;
        if (w_accept) begin
          r_accepted <= i_result;
          r_key_held <= (i_result.kind == SCAN_SINGLE);
          // Roll-over SINGLE(a) -> SINGLE(b) lands here too and counts as a press.
          if (i_result.kind == SCAN_SINGLE) begin
            r_press    <= 1'b1;
            r_key_code <= i_result.code;
          end
        end
      end
    end
  end

  assign o_press    = r_press;
  assign o_key_code = r_key_code;
  assign o_key_held = r_key_held;

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 matrix keypad scanner. Walks one low column at a time, samples
// the synchronized rows at the end of each column period, classifies each
// 4-column frame, debounces it, and shifts accepted keys into a 4-digit register.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   row        : keypad rows, active-low, asynchronous
//   col        : keypad columns, active-low, one-hot-low
//   clear      : one-cycle request to zero digits
//   key_code   : last accepted key
//   key_valid  : one-cycle pulse per accepted press
//   key_held   : accepted frame result is a single key
//   digits     : last four keys, newest in [3:0]
module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_rs;
  logic [DIV_W-1:0] r_div;
  col_state_t       r_col_state;
  logic [3:0]       r_col;
  logic [2:0]       r_low_cnt;
  logic [3:0]       r_acc_code;
  logic [15:0]      r_digits;

  col_state_t       w_col_state_nxt;
  logic [3:0]       w_col_nxt;
  logic             w_div_last;
  logic [1:0]       w_col_idx;
  logic [2:0]       w_sample_lows;
  logic [3:0]       w_sample_code;
  logic [3:0]       w_sum;
  logic [2:0]       w_total;
  logic [3:0]       w_frame_code;
  logic             w_frame_stb;
  scan_result_t     w_frame_result;
  logic             w_press;
  logic [3:0]       w_key_code;
  logic             w_key_held;

  // Two-flop synchronizer on the asynchronous rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_meta <= 4'h0;
      r_rs       <= 4'h0;
    end else begin
      r_row_meta <= row;
      r_rs       <= r_row_meta;
    end
  end

  // Column period divider.
  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else begin
      r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
    end
  end

  // Column scan FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_state <= COL0;
      r_col       <= 4'b1110;
    end else begin
      r_col_state <= w_col_state_nxt;
      r_col       <= w_col_nxt;
    end
  end

  // Column scan FSM: advance one column per divider wrap.
  always_comb begin
    w_col_state_nxt = r_col_state;
    w_col_nxt       = r_col;
    if (w_div_last) begin
      case (r_col_state)
        COL0:    begin w_col_state_nxt = COL1; w_col_nxt = 4'b1101; end
        COL1:    begin w_col_state_nxt = COL2; w_col_nxt = 4'b1011; end
        COL2:    begin w_col_state_nxt = COL3; w_col_nxt = 4'b0111; end
        COL3:    begin w_col_state_nxt = COL0; w_col_nxt = 4'b1110; end
        default: begin w_col_state_nxt = COL0; w_col_nxt = 4'b1110; end
      endcase
    end
  end

  // Per-sample decode and frame classification including the current sample.
  always_comb begin
    w_col_idx     = r_col_state;
    w_sample_lows = count_lows(r_rs);
    w_sample_code = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_rs[r]) begin
        w_sample_code = KEYMAP[2'(r)][w_col_idx];
      end
    end
    w_sum        = {1'b0, r_low_cnt} + {1'b0, w_sample_lows};
    w_total      = w_sum[3] ? 3'd7 : w_sum[2:0];
    w_frame_code = (w_sample_lows == 3'd1) ? w_sample_code : r_acc_code;
    w_frame_stb  = w_div_last && (r_col_state == COL3);
    case (w_total)
      3'd0:    w_frame_result = RESULT_NONE;
      3'd1:    w_frame_result = '{kind: SCAN_SINGLE, code: w_frame_code};
      default: w_frame_result = '{kind: SCAN_MULTI, code: 4'h0};
    endcase
  end

  // Frame accumulator; cleared on the column-3 sample that closes the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_low_cnt  <= 3'd0;
      r_acc_code <= 4'h0;
    end else if (w_div_last) begin
      if (r_col_state == COL3) begin
        r_low_cnt  <= 3'd0;
        r_acc_code <= 4'h0;
      end else begin
        r_low_cnt <= w_total;
        if (w_sample_lows == 3'd1) begin
          r_acc_code <= w_sample_code;
        end
      end
    end
  end

  kypd_frame_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .i_frame_stb (w_frame_stb),
    .i_result    (w_frame_result),
    .o_press     (w_press),
    .o_key_code  (w_key_code),
    .o_key_held  (w_key_held)
  );

  // Digit shift register; a coincident clear wipes the old digits first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= 16'h0000;
    end else if (w_press) begin
      r_digits <= clear ? {12'h000, w_key_code} : {r_digits[11:0], w_key_code};
    end else if (clear) begin
      r_digits <= 16'h0000;
    end
  end

  assign col       = r_col;
  assign key_code  = w_key_code;
  assign key_valid = w_press;
  assign key_held  = w_key_held;
  assign digits    = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 2;
  localparam int          FRAME_CYC      = 4 * SCAN_DIV;

  bit          clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clear;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] pressed;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Key values by index row*4+col, straight from the keypad legend.
  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  // Reference model state: -1 = none, 0..15 = single key index, 16 = multi.
  int         m_prev, m_acc, m_cnt;
  logic [3:0] m_code;
  logic [15:0] m_digits;
  bit         m_pending;
  logic [3:0] m_pend_code;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .clear     (clear),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r*4 + c);
  endfunction

  function automatic int classify(input logic [15:0] k);
    int n;
    int idx;
    n = 0;
    idx = -1;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n == 1) return idx;
    return 16;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_col();
    logic [3:0] one;
    one = 4'b0001;
    return {12'h000, ~(one << ((cyc / SCAN_DIV) % 4))};
  endfunction

  task automatic model_reset();
    m_prev = -1; m_acc = -1; m_cnt = 0; m_code = 4'h0;
    m_digits = 16'h0; m_pending = 1'b0; m_pend_code = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    model_reset();
    check("rst_col", {12'h0, col}, 16'h000E);
    check("rst_code", {12'h0, key_code}, 16'h0);
    check("rst_valid", {15'h0, key_valid}, 16'h0);
    check("rst_held", {15'h0, key_held}, 16'h0);
    check("rst_digits", digits, 16'h0);
  endtask

  // One aligned frame with a fixed key set; clr is driven in the first cycle,
  // which is where the previous frame's key_valid pulse sits.
  task automatic frame(input logic [15:0] keys, input bit clr);
    int res;
    bit pulse;
    clear   = clr;
    pressed = keys;
    @(posedge clk); #1;
    cyc++;
    clear = 1'b0;
    if (m_pending) m_digits = clr ? {12'h000, m_pend_code} : {m_digits[11:0], m_pend_code};
    else if (clr)  m_digits = 16'h0;
    m_pending = 1'b0;
    check("digits", digits, m_digits);
    check("col", {12'h0, col}, exp_col());
    check("valid_low", {15'h0, key_valid}, 16'h0);
    for (int i = 1; i < FRAME_CYC - 1; i++) begin
      @(posedge clk); #1;
      cyc++;
      check("col", {12'h0, col}, exp_col());
      check("valid_low", {15'h0, key_valid}, 16'h0);
    end
    @(posedge clk); #1;
    cyc++;
    res = classify(keys);
    if (res == m_prev) m_cnt = (m_cnt < DEBOUNCE_SCANS) ? m_cnt + 1 : DEBOUNCE_SCANS;
    else               m_cnt = 1;
    m_prev = res;
    pulse  = 1'b0;
    if (m_cnt == DEBOUNCE_SCANS && res != m_acc) begin
      m_acc = res;
      if (res >= 0 && res < 16) begin
        pulse       = 1'b1;
        m_code      = key_map[res];
        m_pending   = 1'b1;
        m_pend_code = m_code;
      end
    end
    check("col", {12'h0, col}, exp_col());
    check("valid_pulse", {15'h0, key_valid}, {15'h0, pulse});
    check("key_code", {12'h0, key_code}, {12'h0, m_code});
    check("key_held", {15'h0, key_held}, {15'h0, (m_acc >= 0 && m_acc < 16)});
  endtask

  initial begin
    logic [15:0] k5, k7, k1, k2, k3, ka, k0, kf;
    logic [15:0] seq_keys [5];
    logic [15:0] rk;
    int a, b;
    k5 = key(1, 1); k7 = key(2, 0);
    k1 = key(0, 0); k2 = key(0, 1); k3 = key(0, 2); ka = key(0, 3);
    k0 = key(3, 0); kf = key(3, 1);
    seq_keys = '{k1, k2, k3, ka, k0};

    pressed = 16'h0;
    clear   = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle scanning
    repeat (3) frame(16'h0, 1'b0);

    // Single press of '5', then release
    repeat (5) frame(k5, 1'b0);
    check("t2_code", {12'h0, key_code}, 16'h0005);
    check("t2_held", {15'h0, key_held}, 16'h0001);
    check("t2_digits", digits, 16'h0005);
    repeat (3) frame(16'h0, 1'b0);
    check("t2_release_held", {15'h0, key_held}, 16'h0);

    // Bouncing '7' never settles
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? k7 : 16'h0, 1'b0);
    frame(16'h0, 1'b0);
    check("t3_digits", digits, 16'h0005);

    // Sequence 1,2,3,A,0
    for (int i = 0; i < 5; i++) begin
      repeat (2) frame(seq_keys[i], 1'b0);
      repeat (2) frame(16'h0, 1'b0);
    end
    frame(16'h0, 1'b0);
    check("t4_digits", digits, 16'h23A0);

    // Two keys together, then release one
    repeat (3) frame(k1 | k2, 1'b0);
    check("t5_multi_held", {15'h0, key_held}, 16'h0);
    repeat (2) frame(k2, 1'b0);
    check("t5_code", {12'h0, key_code}, 16'h0002);
    repeat (2) frame(16'h0, 1'b0);

    // Clear coinciding with the 'F' press pulse, then reset mid-press
    repeat (2) frame(kf, 1'b0);
    frame(kf, 1'b1);
    check("t6_clear_digits", digits, 16'h000F);
    repeat (7) @(posedge clk);
    #1;
    do_reset();
    repeat (2) frame(kf, 1'b0);
    check("t6_repress_code", {12'h0, key_code}, 16'h000F);
    frame(16'h0, 1'b0);
    check("t6_repress_digits", digits, 16'h000F);

    // Random key sets with random hold lengths and occasional clears
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: rk = 16'h0;
        1: rk = key($urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          rk = key(a / 4, a % 4) | key(b / 4, b % 4);
        end
      endcase
      repeat ($urandom_range(1, 4)) frame(rk, ($urandom_range(0, 5) == 0));
    end
    frame(16'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
